ahb_uart_loader: RTL

Boot-image loader acting as AHB-Lite master in front of the on-chip 16 KB program memory. It consumes the byte stream from the UART receiver, parses a framed image, writes it word by word into memory, and holds the Cortex-M0 in reset until a complete, checksum-valid image has been written. It shares the memory's AHB-Lite port with the processor through the existing master mux; `cpu_hold` selects the loader.

---
 rtl/ahb_uart_loader.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_uart_loader.sv
// Boot-image loader: parses a framed image from the UART byte stream and
// writes it word by word over AHB-Lite. It holds the CPU in reset until a
// complete image with a matching checksum has reached memory.
//
// Handshakes: rx_valid is a one-cycle strobe, and the byte is consumed in
// the same cycle with no back-pressure. On the AHB side, an address or data
// phase is held unchanged until a cycle in which HREADY=1. That cycle ends
// the phase.
module ahb_uart_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        HREADY,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_written,
    output logic [2:0]  o_parser_state,
    output logic [1:0]  o_wr_state
);

    localparam logic [2:0] S_HUNT  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;

    localparam logic [1:0]  T_IDLE   = 2'b00;
    localparam logic [1:0]  T_NONSEQ = 2'b10;
    localparam logic [16:0] L_MAX    = 17'(MAX_WORDS);

    logic [2:0]  r_pstate;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [23:0] r_asm;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_word_idx;
    logic [7:0]  r_xor;
    logic        r_load_done;
    logic        r_load_error;
    logic        r_cpu_hold;

    logic [1:0]  r_wstate;
    logic [31:0] r_hold;
    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [31:0] r_hwdata;
    logic [15:0] r_words_written;

    logic [31:0] w_new_word;
    logic [15:0] w_len;
    logic        w_word_complete;
    logic        w_overflow;
    logic        w_word_req;
    logic        w_last_word;
    logic        w_len_bad;
    logic        w_csum_bad;
    logic        w_err;
    logic        w_sync;
    logic        w_clr_ww;

    // Decode the incoming byte against the current parser state.
    always_comb begin
        w_new_word      = {rx_data, r_asm};
        w_len           = {rx_data, r_len_lo};
        w_word_complete = rx_valid && (r_pstate == S_DATA) && (r_byte_cnt == 2'd3);
        // The holding register still belongs to the engine until it returns to idle.
        w_overflow      = w_word_complete && (r_wstate != W_IDLE);
        w_word_req      = w_word_complete && !w_overflow;
        w_last_word     = (r_word_idx == (r_len - 16'd1));
        w_len_bad       = rx_valid && (r_pstate == S_LEN1) &&
                          ((w_len == 16'd0) || ({1'b0, w_len} > L_MAX));
        w_csum_bad      = rx_valid && (r_pstate == S_CSUM) && (rx_data != r_xor);
        w_err           = w_len_bad || w_overflow || w_csum_bad;
        w_sync          = rx_valid && (r_pstate == S_HUNT) && (rx_data == 8'h55);
        w_clr_ww        = w_err || w_sync;
    end

    // Frame parser: length, word assembly, checksum and final handover.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pstate     <= S_HUNT;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_asm        <= 24'd0;
            r_byte_cnt   <= 2'd0;
            r_word_idx   <= 16'd0;
            r_xor        <= 8'd0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_cpu_hold   <= 1'b1;
        end else if (w_err) begin
            r_pstate     <= S_HUNT;
            r_load_error <= 1'b1;
            r_xor        <= 8'd0;
        end else begin
            case (r_pstate)
                S_HUNT: begin
                    if (w_sync) begin
                        r_pstate   <= S_LEN0;
                        r_xor      <= 8'd0;
                        r_byte_cnt <= 2'd0;
                        r_word_idx <= 16'd0;
                    end
                end
                S_LEN0: begin
                    if (rx_valid) begin
                        r_len_lo <= rx_data;
                        r_pstate <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (rx_valid) begin
                        r_len    <= w_len;
                        r_pstate <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_asm      <= {rx_data, r_asm[23:8]};
                        r_xor      <= r_xor ^ rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_word_idx <= r_word_idx + 16'd1;
                            if (w_last_word) begin
                                r_pstate <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        r_pstate <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Release the CPU only once the last write has left the bus.
                    if (r_wstate == W_IDLE) begin
                        r_pstate    <= S_DONE;
                        r_load_done <= 1'b1;
                        r_cpu_hold  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Write engine: one SINGLE word write per assembled word, address then data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wstate <= W_IDLE;
            r_hold   <= 32'd0;
            r_haddr  <= 32'd0;
            r_htrans <= T_IDLE;
            r_hwrite <= 1'b0;
            r_hwdata <= 32'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_word_req) begin
                        r_wstate <= W_ADDR;
                        r_hold   <= w_new_word;
                        r_haddr  <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                        r_htrans <= T_NONSEQ;
                        r_hwrite <= 1'b1;
                    end
                end
                W_ADDR: begin
                    if (HREADY) begin
                        r_wstate <= W_DATA;
                        r_htrans <= T_IDLE;
                        r_hwrite <= 1'b0;
                        r_hwdata <= r_hold;
                    end
                end
                W_DATA: begin
                    if (HREADY) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Completed data phases in the current frame; a new frame or an error restarts the count.
    always_ff @(posedge HCLK) begin
        if (HRESET || w_clr_ww) begin
            r_words_written <= 16'd0;
        end else if ((r_wstate == W_DATA) && HREADY) begin
            r_words_written <= r_words_written + 16'd1;
        end
    end

    assign HADDR          = r_haddr;
    assign HTRANS         = r_htrans;
    assign HWRITE         = r_hwrite;
    assign HSIZE          = 3'b010;
    assign HBURST         = 3'b000;
    assign HPROT          = 4'b0011;
    assign HWDATA         = r_hwdata;
    assign cpu_hold       = r_cpu_hold;
    assign load_done      = r_load_done;
    assign load_error     = r_load_error;
    assign words_written  = r_words_written;
    assign o_parser_state = r_pstate;
    assign o_wr_state     = r_wstate;

endmodule
